execute_cycle: RTL and testbench
================================

EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on this edge only.
REQ-002 rst  in  1  synchronous, active-low reset; rst=0 at a clk edge clears the stage, rst=1 runs.
REQ-003 RegWriteE, ALUSrcE, MemWriteE, branchE, JumpE  in  1 each  control from the decode stage register.
REQ-004 ResultSrcE  in  2  writeback source select; ALUControlE  in  3  ALU operation.
REQ-005 RD1E, RD2E, PCE, ImmEXTE, PCPlus4E  in  32 each  operands, PC, immediate, PC+4 from decode.
REQ-006 RdE  in  5  destination register index.
REQ-007 ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
REQ-008 ResultW  in  32  writeback-stage result used for forwarding.
REQ-009 PCSrcE  out  1  combinational redirect request to fetch.
REQ-010 PCTargetE  out  32  combinational branch/jump target.
REQ-011 RegWriteM, MemWriteM  out  1 each;  ResultSrcM  out  2;  RdM  out  5  registered controls to the memory stage.
REQ-012 ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered data to the memory stage.

Function
REQ-013 SrcAE SHALL be RD1E when ForwardAE=00, ResultW when 01, and the current ALUResultM register when 10; 11 SHALL select RD1E.
REQ-014 The forwarded B operand (WriteDataE) SHALL use ForwardBE with the same mapping applied to RD2E.
REQ-015 SrcBE SHALL be ImmEXTE when ALUSrcE=1, otherwise WriteDataE.
REQ-016 ALU operations, all 32-bit with carry discarded: 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than (result 1 or 0); 100, 110 and 111 SHALL produce 0.
REQ-017 ZeroE SHALL be 1 when the 32-bit ALU result equals 0.
REQ-018 PCTargetE SHALL equal PCE+ImmEXTE modulo 2^32.
REQ-019 PCSrcE SHALL equal (ZeroE AND branchE) OR JumpE, with zero latency.
REQ-020 On each clk edge with rst=1, the stage SHALL capture RegWriteE, MemWriteE, ResultSrcE, RdE, the ALU result, WriteDataE and PCPlus4E into the M registers, giving one cycle of latency.
REQ-021 Forwarding from ALUResultM SHALL use the value registered at the previous edge; back-to-back dependent ALU ops SHALL complete without a stall.
REQ-022 WriteDataM SHALL carry the forwarded B operand, not raw RD2E.
REQ-023 When rst=0, all M outputs SHALL read 0 combinationally, regardless of register contents.

Reset
REQ-024 At a clk edge with rst=0, every M register SHALL load 0, with RdM=5'b0.
REQ-025 If rst is asserted during an active instruction, that instruction SHALL be discarded; no partial state survives.
REQ-026 On the first edge after rst returns to 1, the stage SHALL capture its inputs normally.
REQ-027 PCSrcE and PCTargetE are not reset and SHALL follow their inputs combinationally.

Configuration
REQ-028 Macro EXECUTE_FORWARDING_EN:
- Defined: the forwarding muxes operate as in REQ-013/014.
- Undefined: SrcAE=RD1E and WriteDataE=RD2E; ForwardAE, ForwardBE and ResultW are ignored.
- Port list is identical in both builds.

Verification
REQ-029 Add with immediate: RD1E=5, ImmEXTE=7, ALUSrcE=1, ALUControlE=000, RegWriteE=1, RdE=3 -> after one edge ALUResultM=12, RdM=3, RegWriteM=1.
REQ-030 Taken branch: RD1E=RD2E=9, ALUControlE=001, branchE=1, PCE=0x100, ImmEXTE=0x20 -> PCSrcE=1 and PCTargetE=0x120 in the same cycle.
REQ-031 Forwarding (EXECUTE_FORWARDING_EN defined):
- Cycle 1: add produces ALUResultM=12.
- Cycle 2: ForwardAE=10, RD1E=0, ImmEXTE=1, add -> ALUResultM=13.
- With ForwardBE=01, ResultW=0x55 -> WriteDataM=0x55.
REQ-032 Signed SLT: SrcA=0xFFFFFFFF, SrcB=1, ALUControlE=101 -> ALUResultM=1; with the operands swapped -> 0.
REQ-033 Reset mid-stream: load ALUResultM=0x1234, then drive rst=0 for one edge -> all M outputs 0; restore rst=1 and apply a new add -> the correct result appears after one edge.
REQ-034 Macro undefined: ForwardAE=10, RD1E=4, ImmEXTE=4 -> ALUResultM=8 (forwarding input ignored).

Source files
------------

// File: rtl/execute_cycle.sv
// execute_cycle -- RISC-V style execute stage with EX/MEM pipeline register.
// Operand forwarding muxes are built only when EXECUTE_FORWARDING_EN is
// defined; otherwise the A/B operands come straight from the register file
// reads. The port list is the same in both builds.
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        branchE,
  input  logic        JumpE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] PCE,
  input  logic [31:0] ImmEXTE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  // EX/MEM pipeline registers
  logic        r_reg_write;
  logic        r_mem_write;
  logic [1:0]  r_result_src;
  logic [4:0]  r_rd;
  logic [31:0] r_alu_result;
  logic [31:0] r_write_data;
  logic [31:0] r_pc_plus4;

  logic [31:0] w_src_a;
  logic [31:0] w_write_data;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_result;
  logic        w_zero;

`ifdef EXECUTE_FORWARDING_EN
  // A operand: register file, writeback result, or the value this stage
  // registered at the previous edge (back-to-back dependency, no stall)
  always_comb begin
    w_src_a = RD1E;
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = r_alu_result;
      default: w_src_a = RD1E;
    endcase
  end

  // B operand forwarding; this forwarded value is also the store data
  always_comb begin
    w_write_data = RD2E;
    case (ForwardBE)
      2'b01:   w_write_data = ResultW;
      2'b10:   w_write_data = r_alu_result;
      default: w_write_data = RD2E;
    endcase
  end
`else
  // Forwarding disabled: the hazard-unit inputs are deliberately ignored
  logic w_unused_fwd;
  assign w_unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
  assign w_src_a      = RD1E;
  assign w_write_data = RD2E;
`endif

  assign w_src_b = ALUSrcE ? ImmEXTE : w_write_data;

  // ALU; unused encodings yield zero so they still produce a defined result
  always_comb begin
    w_alu_result = 32'd0;
    case (ALUControlE)
      3'b000:  w_alu_result = w_src_a + w_src_b;
      3'b001:  w_alu_result = w_src_a - w_src_b;
      3'b010:  w_alu_result = w_src_a & w_src_b;
      3'b011:  w_alu_result = w_src_a | w_src_b;
      3'b101:  w_alu_result = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
      default: w_alu_result = 32'd0;
    endcase
  end

  assign w_zero    = (w_alu_result == 32'd0);
  assign PCTargetE = PCE + ImmEXTE;
  assign PCSrcE    = (w_zero & branchE) | JumpE;

  // Capture the instruction into the M stage; active-low reset discards it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_rd         <= 5'd0;
      r_alu_result <= 32'd0;
      r_write_data <= 32'd0;
      r_pc_plus4   <= 32'd0;
    end else begin
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_result_src <= ResultSrcE;
      r_rd         <= RdE;
      r_alu_result <= w_alu_result;
      r_write_data <= w_write_data;
      r_pc_plus4   <= PCPlus4E;
    end
  end

  // While reset is held the M outputs read zero immediately, before any edge
  assign RegWriteM  = rst ? r_reg_write  : 1'b0;
  assign MemWriteM  = rst ? r_mem_write  : 1'b0;
  assign ResultSrcM = rst ? r_result_src : 2'b00;
  assign RdM        = rst ? r_rd         : 5'd0;
  assign ALUResultM = rst ? r_alu_result : 32'd0;
  assign WriteDataM = rst ? r_write_data : 32'd0;
  assign PCPlus4M   = rst ? r_pc_plus4   : 32'd0;

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle -- directed vector bench for execute_cycle.
// Expected forwarding results depend on EXECUTE_FORWARDING_EN.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, branchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmEXTE, PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int n_tests = 0;
  int n_fail  = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .branchE(branchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .ImmEXTE(ImmEXTE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        regw, alusrc, memw, br, jmp;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, pc, imm, pc4;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
    logic [31:0] resw;
    logic [31:0] exp_alu, exp_wd, exp_tgt;
    logic        exp_pcsrc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RegWriteE = v.regw; ALUSrcE = v.alusrc; MemWriteE = v.memw;
    branchE = v.br; JumpE = v.jmp; ResultSrcE = v.rsrc; ALUControlE = v.aluc;
    RD1E = v.rd1; RD2E = v.rd2; PCE = v.pc; ImmEXTE = v.imm; PCPlus4E = v.pc4;
    RdE = v.rd; ForwardAE = v.fa; ForwardBE = v.fb; ResultW = v.resw;
  endtask

  // Drive at negedge, check redirect mid-cycle, check M outputs after the edge
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " PCSrcE"}, {31'd0, PCSrcE}, {31'd0, v.exp_pcsrc});
    chk({tag, " PCTargetE"}, PCTargetE, v.exp_tgt);
    @(posedge clk);
    #1;
    chk({tag, " ALUResultM"}, ALUResultM, v.exp_alu);
    chk({tag, " WriteDataM"}, WriteDataM, v.exp_wd);
    chk({tag, " RdM"}, {27'd0, RdM}, {27'd0, v.rd});
    chk({tag, " RegWriteM"}, {31'd0, RegWriteM}, {31'd0, v.regw});
    chk({tag, " MemWriteM"}, {31'd0, MemWriteM}, {31'd0, v.memw});
    chk({tag, " ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, v.rsrc});
    chk({tag, " PCPlus4M"}, PCPlus4M, v.pc4);
    $display("[TB] %s alu=0x%08h wd=0x%08h pcsrc=%0b tgt=0x%08h",
             tag, ALUResultM, WriteDataM, PCSrcE, PCTargetE);
  endtask

  task automatic chk_m_zero(input string tag);
    chk({tag, " ALUResultM"}, ALUResultM, 32'd0);
    chk({tag, " WriteDataM"}, WriteDataM, 32'd0);
    chk({tag, " PCPlus4M"}, PCPlus4M, 32'd0);
    chk({tag, " RdM"}, {27'd0, RdM}, 32'd0);
    chk({tag, " ctrl"}, {28'd0, RegWriteM, MemWriteM, ResultSrcM}, 32'd0);
  endtask

  vec_t tbl[14];
  vec_t fwd[6];
  vec_t v;

  initial begin
    // ---- vector table: ALU ops, branch/jump, target arithmetic ----
    tbl[0]  = '{regw:1, alusrc:1, aluc:3'b000, rd1:5, imm:7, rd:3, pc4:32'h4,
                exp_alu:12, exp_wd:0, exp_tgt:7, exp_pcsrc:0, default:0};
    tbl[1]  = '{aluc:3'b001, rd1:9, rd2:9, br:1, pc:32'h100, imm:32'h20, pc4:32'h104,
                exp_alu:0, exp_wd:9, exp_tgt:32'h120, exp_pcsrc:1, default:0};
    tbl[2]  = '{aluc:3'b001, rd1:9, rd2:8, br:1, pc:32'h200, imm:32'hFFFF_FFF0,
                exp_alu:1, exp_wd:8, exp_tgt:32'h1F0, exp_pcsrc:0, default:0};
    tbl[3]  = '{memw:1, rsrc:2'b01, rd:7, aluc:3'b010, rd1:32'hF0F0_1234, rd2:32'h0FF0_FF00,
                exp_alu:32'h00F0_1200, exp_wd:32'h0FF0_FF00, exp_tgt:0, exp_pcsrc:0, default:0};
    tbl[4]  = '{regw:1, rsrc:2'b10, rd:31, aluc:3'b011, rd1:32'hF000_0001, rd2:32'h0000_0F10,
                pc4:32'hDEAD_BEEF, exp_alu:32'hF000_0F11, exp_wd:32'h0000_0F10, exp_tgt:0,
                exp_pcsrc:0, default:0};
    tbl[5]  = '{alusrc:1, aluc:3'b101, rd1:32'hFFFF_FFFF, imm:1, rd2:32'hAAAA,
                exp_alu:1, exp_wd:32'hAAAA, exp_tgt:1, exp_pcsrc:0, default:0};
    tbl[6]  = '{alusrc:1, aluc:3'b101, rd1:1, imm:32'hFFFF_FFFF,
                exp_alu:0, exp_wd:0, exp_tgt:32'hFFFF_FFFF, exp_pcsrc:0, default:0};
    tbl[7]  = '{aluc:3'b101, rd1:32'h8000_0000, rd2:1, br:1,
                exp_alu:1, exp_wd:1, exp_tgt:0, exp_pcsrc:0, default:0};
    tbl[8]  = '{aluc:3'b100, rd1:3, rd2:4, br:1, pc:32'h40, imm:8,
                exp_alu:0, exp_wd:4, exp_tgt:32'h48, exp_pcsrc:1, default:0};
    tbl[9]  = '{aluc:3'b110, rd1:32'h10, rd2:32'h20,
                exp_alu:0, exp_wd:32'h20, exp_tgt:0, exp_pcsrc:0, default:0};
    tbl[10] = '{aluc:3'b111, rd1:32'h10, rd2:32'h20, jmp:1, pc:32'hFFFF_FFFC, imm:8,
                exp_alu:0, exp_wd:32'h20, exp_tgt:4, exp_pcsrc:1, default:0};
    tbl[11] = '{alusrc:1, aluc:3'b000, rd1:32'hFFFF_FFFF, imm:2, br:1,
                exp_alu:1, exp_wd:0, exp_tgt:2, exp_pcsrc:0, default:0};
    tbl[12] = '{aluc:3'b001, rd1:3, rd2:5, jmp:1, pc:32'h1000, imm:32'h10,
                exp_alu:32'hFFFF_FFFE, exp_wd:5, exp_tgt:32'h1010, exp_pcsrc:1, default:0};
    tbl[13] = '{aluc:3'b101, rd1:3, rd2:5,
                exp_alu:1, exp_wd:5, exp_tgt:0, exp_pcsrc:0, default:0};

    // ---- forwarding sequence (rows are dependent on each other) ----
    fwd[0] = '{alusrc:1, aluc:3'b000, rd1:5, imm:7, regw:1, rd:3,
               exp_alu:12, exp_wd:0, exp_tgt:7, exp_pcsrc:0, default:0};
`ifdef EXECUTE_FORWARDING_EN
    fwd[1] = '{fa:2'b10, alusrc:1, rd1:0, imm:1,
               exp_alu:13, exp_wd:0, exp_tgt:1, exp_pcsrc:0, default:0};
    fwd[2] = '{fa:2'b01, fb:2'b01, resw:32'h55, rd1:0, rd2:32'h11,
               exp_alu:32'hAA, exp_wd:32'h55, exp_tgt:0, exp_pcsrc:0, default:0};
`else
    fwd[1] = '{fa:2'b10, alusrc:1, rd1:0, imm:1,
               exp_alu:1, exp_wd:0, exp_tgt:1, exp_pcsrc:0, default:0};
    fwd[2] = '{fa:2'b01, fb:2'b01, resw:32'h55, rd1:0, rd2:32'h11,
               exp_alu:32'h11, exp_wd:32'h11, exp_tgt:0, exp_pcsrc:0, default:0};
`endif
    fwd[3] = '{fa:2'b11, fb:2'b11, resw:32'h55, rd1:4, rd2:6,
               exp_alu:10, exp_wd:6, exp_tgt:0, exp_pcsrc:0, default:0};
`ifdef EXECUTE_FORWARDING_EN
    fwd[4] = '{fa:2'b10, alusrc:1, rd1:4, imm:4,
               exp_alu:14, exp_wd:0, exp_tgt:4, exp_pcsrc:0, default:0};
    fwd[5] = '{fb:2'b10, alusrc:1, rd1:0, imm:0, rd2:32'h99,
               exp_alu:0, exp_wd:14, exp_tgt:0, exp_pcsrc:0, default:0};
`else
    fwd[4] = '{fa:2'b10, alusrc:1, rd1:4, imm:4,
               exp_alu:8, exp_wd:0, exp_tgt:4, exp_pcsrc:0, default:0};
    fwd[5] = '{fb:2'b10, alusrc:1, rd1:0, imm:0, rd2:32'h99,
               exp_alu:0, exp_wd:32'h99, exp_tgt:0, exp_pcsrc:0, default:0};
`endif

    // ---- reset with a live instruction on the inputs ----
    rst = 1'b0;
    drive(tbl[4]);
    repeat (2) @(posedge clk);
    #1;
    chk_m_zero("reset");
    $display("[TB] reset alu=0x%08h rd=%0d", ALUResultM, RdM);

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) run_vec(fwd[i], $sformatf("fwd%0d", i));

    // ---- reset mid-stream ----
    v = '{regw:1, memw:1, rsrc:2'b11, rd:9, alusrc:1, aluc:3'b000, rd1:32'h1234, imm:0,
          rd2:32'h77, pc4:32'h88, exp_alu:32'h1234, exp_wd:32'h77, exp_tgt:0,
          exp_pcsrc:0, default:0};
    run_vec(v, "preload");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_m_zero("rst_comb");
    $display("[TB] rst_comb alu=0x%08h", ALUResultM);
    @(posedge clk);
    #1;
    chk_m_zero("rst_edge");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_m_zero("rst_release");
    $display("[TB] rst_release alu=0x%08h rd=%0d", ALUResultM, RdM);
    v = '{regw:1, rd:4, alusrc:1, aluc:3'b000, rd1:2, imm:3, pc4:32'h24,
          exp_alu:5, exp_wd:0, exp_tgt:3, exp_pcsrc:0, default:0};
    run_vec(v, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
